fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch and program-sequencing block that drives the program counter into instruction memory and supplies the 9-bit machine word to the control decoder. It consumes the decoder's `Branch` and 5-bit `addr` outputs on the return path, resolving taken jumps through a 32-entry branch-target lookup table. It also runs the start/done handshake with the testbench or top level, detects the halt opcode, and counts execution cycles.

## Interface
- `PC_W`, 10, program counter width (instruction memory depth 2^PC_W)
- `IW`, 9, instruction width
- `LUT_N`, 32, branch-target LUT entries (index width 5)
- `CNT_W`, 16, cycle counter width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin program execution
- `instr`  in  IW  word read from instruction memory at `prog_addr` (combinational read)
- `branch`  in  1  taken-branch indication from control decoder
- `branch_idx`  in  5  LUT index from control decoder (`addr`)
- `prog_addr`  out  PC_W  current program counter
- `running`  out  1  high while state is RUN
- `done`  out  1  high while state is DONE
- `cycle_count`  out  CNT_W  cycles spent in RUN for current/last program
- `lut_we`, `lut_widx[4:0]`, `lut_wdata[PC_W-1:0]`  in  exist only with FETCH_LUT_WR_EN

## Operation
- States: IDLE, RUN, DONE. Encoded as package enum.
- Reset (any state, mid-program included): state IDLE, `prog_addr`=0, `cycle_count`=0, `running`=0, `done`=0; LUT restored to package defaults.
- IDLE: `prog_addr` held 0; `start`=1 -> RUN next cycle, `cycle_count` cleared to 0.
- RUN, per cycle, priority order:
  1. `instr[8:5]` == HALT_OP (4'b1111) -> DONE; `prog_addr` holds (points at halt word); `branch` ignored.
  2. `branch`=1 -> `prog_addr` <= LUT[`branch_idx`].
  3. otherwise `prog_addr` <= `prog_addr`+1, modulo 2^PC_W (max value wraps to 0, no flag).
- `cycle_count` increments each RUN cycle, including the halt cycle; saturates at 2^CNT_W-1.
- `start` in RUN ignored.
- DONE: `done` held high, `prog_addr` and `cycle_count` frozen; `start`=1 -> RUN with `prog_addr`=0, `cycle_count`=0.
- Branch LUT entries are PC_W bits; an index selects exactly one entry, with no arithmetic on the target.

## Timing
- All outputs registered; `running`/`done` decoded from the state register.
- Start latency: `start` at edge N -> `running`=1 and fetch of address 0 in cycle N+1.
- Branch latency: zero bubbles; `branch` sampled in the same cycle as the jump instruction is presented, target address presented next cycle.
- Halt: halt word visible in cycle H -> `done`=1 in cycle H+1.
- `reset` and `start` asserted together: reset wins.

## Configuration
- `FETCH_LUT_WR_EN` defined: LUT is a register array, reset to package defaults; `lut_we`=1 writes `lut_wdata` to entry `lut_widx` at the clock edge, in any state. A same-cycle branch reading that entry gets the old value.
- Not defined: LUT write ports absent; LUT is constant package defaults (synthesizes to logic).

## Structure
- Shared package `fetch_pkg`: state enum, HALT_OP, default LUT contents (LUT_N x PC_W constant array), LUT index width.
- One sub-module, `branch_lut`: holds table, async read, optional write port under the macro.
- Top holds FSM, PC, and cycle counter.

## Test plan
- Reset, then `start` pulse; program 0..4 non-branch, word 5 = 9'b1111_00000 -> `prog_addr` 0,1,2,3,4,5; `done`=1 one cycle after addr 5; `cycle_count`=6.
- At addr 3, `branch`=1, `branch_idx`=7, LUT[7]=20 -> next `prog_addr`=20, then 21.
- Halt word with `branch`=1 simultaneously -> DONE, `prog_addr` stays at halt address.
- Program of PC=1023 non-halt -> `prog_addr` wraps to 0; counter continues.
- `reset` asserted mid-RUN at addr 12 -> next cycle IDLE, `prog_addr`=0, `cycle_count`=0; then `start` in DONE restarts at 0.
- With FETCH_LUT_WR_EN: write LUT[2]=100 while `branch_idx`=2 taken same cycle -> jump to old default; next branch via index 2 -> 100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch block: FSM states,
// halt opcode, widths and the power-on contents of the branch-target table.
package fetch_pkg;

    localparam int PC_W      = 10;
    localparam int IW        = 9;
    localparam int LUT_N     = 32;
    localparam int LUT_IDX_W = 5;
    localparam int CNT_W     = 16;

    localparam logic [3:0] HALT_OP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef logic [PC_W-1:0]      pc_t;
    typedef logic [IW-1:0]        instr_t;
    typedef logic [LUT_IDX_W-1:0] lut_idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    localparam pc_t LUT_DEFAULT [LUT_N] = '{
        10'd0,   10'd16,  10'd40,  10'd64,  10'd100, 10'd128, 10'd200, 10'd20,
        10'd256, 10'd300, 10'd333, 10'd400, 10'd450, 10'd500, 10'd512, 10'd600,
        10'd640, 10'd700, 10'd720, 10'd768, 10'd800, 10'd850, 10'd900, 10'd960,
        10'd1000, 10'd1010, 10'd1020, 10'd1023, 10'd8, 10'd50,  10'd90,  10'd12
    };

    // Opcode lives in the top four bits; masking keeps the whole word in use.
    localparam instr_t HALT_MASK  = {4'b1111, {(IW-4){1'b0}}};
    localparam instr_t HALT_MATCH = {HALT_OP, {(IW-4){1'b0}}};

    function automatic logic is_halt(input instr_t word);
        return (word & HALT_MASK) == HALT_MATCH;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: start/done handshake, instruction-memory port and the
// decoder's branch return path.
interface fetch_unit_if;

    logic                 start;
    fetch_pkg::instr_t    instr;
    logic                 branch;
    fetch_pkg::lut_idx_t  branch_idx;
    fetch_pkg::pc_t       prog_addr;
    logic                 running;
    logic                 done;
    fetch_pkg::cnt_t      cycle_count;

    modport master (
        input  start, instr, branch, branch_idx,
        output prog_addr, running, done, cycle_count
    );

    modport slave (
        output start, instr, branch, branch_idx,
        input  prog_addr, running, done, cycle_count
    );

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target table with combinational read. Writable register array when
// FETCH_LUT_WR_EN is defined, otherwise constant package defaults.
module branch_lut
    import fetch_pkg::*;
(
`ifdef FETCH_LUT_WR_EN
    input  logic     clk,
    input  logic     reset,
    input  logic     we_i,
    input  lut_idx_t widx_i,
    input  pc_t      wdata_i,
`endif
    input  lut_idx_t rd_idx_i,
    output pc_t      rd_data_o
);

`ifdef FETCH_LUT_WR_EN
    pc_t lut_q [LUT_N];

    // NOTE: this table is reset like ordinary state because reset must bring
    // back the default targets; it is small enough to live in flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= LUT_DEFAULT[i];
            end
        end else if (we_i) begin
            lut_q[widx_i] <= wdata_i;
        end
    end

    assign rd_data_o = lut_q[rd_idx_i];
`else
    assign rd_data_o = LUT_DEFAULT[rd_idx_i];
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / program sequencer: IDLE/RUN/DONE FSM, program counter,
// saturating cycle counter. FETCH_LUT_WR_EN adds the branch-table write port.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
`ifdef FETCH_LUT_WR_EN
    input  logic     lut_we,
    input  lut_idx_t lut_widx,
    input  pc_t      lut_wdata,
`endif
    fetch_unit_if.master bus
);

    state_e state_q, state_d;
    pc_t    pc_q, pc_d;
    cnt_t   cnt_q, cnt_d;
    pc_t    lut_target;

    branch_lut u_branch_lut (
`ifdef FETCH_LUT_WR_EN
        .clk       (clk),
        .reset     (reset),
        .we_i      (lut_we),
        .widx_i    (lut_widx),
        .wdata_i   (lut_wdata),
`endif
        .rd_idx_i  (bus.branch_idx),
        .rd_data_o (lut_target)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);
                // Halt outranks a simultaneous branch; the PC stays on the halt word.
                if (is_halt(bus.instr)) begin
                    state_d = ST_DONE;
                end else if (bus.branch) begin
                    pc_d = lut_target;
                end else begin
                    pc_d = pc_q + pc_t'(1);
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.prog_addr   = pc_q;
    assign bus.cycle_count = cnt_q;
    assign bus.running     = (state_q == ST_RUN);
    assign bus.done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared each cycle against a behavioural sequencer model.
module tb_fetch_unit;

    localparam int MEM_N   = 1024;
    localparam int CNT_MAX = 65535;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    logic [8:0] imem [MEM_N];
    assign bus.instr = imem[bus.prog_addr];

`ifdef FETCH_LUT_WR_EN
    logic       lut_we;
    logic [4:0] lut_widx;
    logic [9:0] lut_wdata;
`endif

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
`ifdef FETCH_LUT_WR_EN
        .lut_we    (lut_we),
        .lut_widx  (lut_widx),
        .lut_wdata (lut_wdata),
`endif
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = idle, 1 = run, 2 = done.
    int m_state;
    int m_pc;
    int m_cnt;
    int tbl [32];
    int tbl_init [32] = '{
        0, 16, 40, 64, 100, 128, 200, 20,
        256, 300, 333, 400, 450, 500, 512, 600,
        640, 700, 720, 768, 800, 850, 900, 960,
        1000, 1010, 1020, 1023, 8, 50, 90, 12
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: model computes next state from the inputs now
    // applied, then DUT outputs are compared at the following falling edge.
    task automatic tick();
        int ns, npc, ncnt;
        ns   = m_state;
        npc  = m_pc;
        ncnt = m_cnt;
        if (reset) begin
            ns = 0; npc = 0; ncnt = 0;
            for (int i = 0; i < 32; i++) tbl[i] = tbl_init[i];
        end else begin
            case (m_state)
                0: if (bus.start) begin ns = 1; npc = 0; ncnt = 0; end
                1: begin
                    ncnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
                    if (imem[m_pc][8:5] == 4'hF) ns = 2;
                    else if (bus.branch) npc = tbl[bus.branch_idx];
                    else npc = (m_pc + 1) % MEM_N;
                end
                default: if (bus.start) begin ns = 1; npc = 0; ncnt = 0; end
            endcase
`ifdef FETCH_LUT_WR_EN
            if (lut_we) tbl[lut_widx] = int'(lut_wdata);
`endif
        end
        @(posedge clk);
        @(negedge clk);
        m_state = ns;
        m_pc    = npc;
        m_cnt   = ncnt;
        check("prog_addr", 32'(bus.prog_addr), m_pc);
        check("running", 32'(bus.running), 32'(m_state == 1));
        check("done", 32'(bus.done), 32'(m_state == 2));
        check("cycle_count", 32'(bus.cycle_count), m_cnt);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_until_pc(input int pc, input int limit);
        for (int i = 0; i < limit && m_pc != pc; i++) tick();
        check("reach_pc", 32'(bus.prog_addr), pc);
    endtask

    task automatic run_until_done(input int limit);
        for (int i = 0; i < limit && m_state != 2; i++) tick();
        check("reach_done", 32'(bus.done), 1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_N; i++) imem[i] = 9'h001;
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.branch     = 1'b0;
        bus.branch_idx = '0;
`ifdef FETCH_LUT_WR_EN
        lut_we    = 1'b0;
        lut_widx  = '0;
        lut_wdata = '0;
`endif
        m_state = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < 32; i++) tbl[i] = tbl_init[i];
        clear_mem();
        @(negedge clk);

        // Reset state
        tick();
        tick();
        check("rst_pc", 32'(bus.prog_addr), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_cnt", 32'(bus.cycle_count), 0);
        reset = 1'b0;
        tick();

        // Straight-line program halting at word 5
        imem[5] = 9'b1111_00000;
        pulse_start();
        check("start_pc", 32'(bus.prog_addr), 0);
        check("start_running", 32'(bus.running), 1);
        run_until_done(100);
        check("halt_pc", 32'(bus.prog_addr), 5);
        check("halt_cnt", 32'(bus.cycle_count), 6);
        tick();
        tick();
        check("done_frozen_pc", 32'(bus.prog_addr), 5);
        check("done_frozen_cnt", 32'(bus.cycle_count), 6);
        imem[5] = 9'h001;

        // Taken branch at addr 3 via index 7, then halt word with branch high
        imem[22] = 9'b1111_00000;
        pulse_start();
        run_until_pc(3, 50);
        bus.branch = 1'b1; bus.branch_idx = 5'd7;
        tick();
        bus.branch = 1'b0;
        check("br_target", 32'(bus.prog_addr), 20);
        tick();
        check("br_next", 32'(bus.prog_addr), 21);
        tick();
        bus.branch = 1'b1; bus.branch_idx = 5'd7;
        tick();
        bus.branch = 1'b0;
        check("halt_over_branch_done", 32'(bus.done), 1);
        check("halt_over_branch_pc", 32'(bus.prog_addr), 22);
        imem[22] = 9'h001;

        // PC wrap from 1023 to 0
        imem[3] = 9'b1111_00000;
        pulse_start();
        run_until_pc(1, 50);
        bus.branch = 1'b1; bus.branch_idx = 5'd27;
        tick();
        bus.branch = 1'b0;
        check("wrap_max", 32'(bus.prog_addr), 1023);
        tick();
        check("wrap_zero", 32'(bus.prog_addr), 0);
        run_until_done(50);
        check("wrap_halt_pc", 32'(bus.prog_addr), 3);
        check("wrap_cnt", 32'(bus.cycle_count), 7);
        imem[3] = 9'h001;

        // Reset mid-run, then restart from DONE
        pulse_start();
        run_until_pc(12, 50);
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        check("midrst_pc", 32'(bus.prog_addr), 0);
        check("midrst_cnt", 32'(bus.cycle_count), 0);
        check("midrst_running", 32'(bus.running), 0);
        imem[14] = 9'b1111_00000;
        pulse_start();
        run_until_done(50);
        pulse_start();
        check("restart_pc", 32'(bus.prog_addr), 0);
        check("restart_cnt", 32'(bus.cycle_count), 0);
        check("restart_running", 32'(bus.running), 1);
        run_until_done(50);
        imem[14] = 9'h001;

`ifdef FETCH_LUT_WR_EN
        // Write LUT[2] while branching through it: old target first
        pulse_start();
        run_until_pc(4, 50);
        lut_we = 1'b1; lut_widx = 5'd2; lut_wdata = 10'd100;
        bus.branch = 1'b1; bus.branch_idx = 5'd2;
        tick();
        lut_we = 1'b0;
        check("lutwr_old", 32'(bus.prog_addr), 40);
        tick();
        bus.branch = 1'b0;
        check("lutwr_new", 32'(bus.prog_addr), 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_start();
        bus.branch = 1'b1; bus.branch_idx = 5'd2;
        tick();
        bus.branch = 1'b0;
        check("lut_restored", 32'(bus.prog_addr), 40);
`endif

        // Cycle counter saturation on a long halt-free run
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_start();
        for (int i = 0; i < CNT_MAX + 100; i++) tick();
        check("cnt_saturate", 32'(bus.cycle_count), CNT_MAX);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < MEM_N; i++) imem[i] = 9'($urandom);
        for (int n = 0; n < 4000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            bus.start      = ($urandom_range(0, 7) == 0);
            bus.branch     = ($urandom_range(0, 5) == 0);
            bus.branch_idx = 5'($urandom);
`ifdef FETCH_LUT_WR_EN
            lut_we    = ($urandom_range(0, 9) == 0);
            lut_widx  = 5'($urandom);
            lut_wdata = 10'($urandom);
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
